// File: rtl/vcve2_pkg.sv
// vcve2_pkg: shared RF write request type and writer-source encoding
package vcve2_pkg;
  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_req_t;
  typedef enum logic [1:0] {WrSrcNone, WrSrcLsu, WrSrcId, WrSrcVec} wr_src_e;
endpackage

// File: rtl/cve2_rf_wr_fifo.sv
// cve2_rf_wr_fifo: sync FIFO of RF write requests exposing every slot address for hazard compare
module cve2_rf_wr_fifo
  import vcve2_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  rf_wr_req_t                 wdata_i,
  input  logic                       pop_i,
  output rf_wr_req_t                 head_o,
  output logic [Depth-1:0][4:0]      entry_waddr_o,
  output logic [Depth-1:0]           valid_o,
  output logic [$clog2(Depth):0]     count_o
);
  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned CW = PW + 1;
  rf_wr_req_t [Depth-1:0] mem;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic full;
  logic do_push;
  logic do_pop;
  // A push into a full FIFO only lands when the head leaves in the same cycle
  always_comb begin
    full = count_o == CW'(Depth);
    do_push = push_i & (!full | pop_i);
    do_pop = pop_i & (count_o != '0);
    head_o = mem[rd_ptr];
    for (int i = 0; i < Depth; i++) begin
      entry_waddr_o[i] = mem[i].waddr;
      valid_o[i] = {1'b0, PW'(i) - rd_ptr} < count_o;
    end
  end
  // Pointer/count bookkeeping; storage itself is not reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count_o <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count_o <= count_o + CW'(do_push) - CW'(do_pop);
    end
  end
  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i & full & !pop_i))
    else $error("fifo overflow");
  assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i & (count_o == '0)))
    else $error("fifo underflow");
endmodule

// File: rtl/cve2_rf_wport_arbiter.sv
// cve2_rf_wport_arbiter: shares the RF write port between LSU, ID and vector writers with hazard flags
module cve2_rf_wport_arbiter
  import vcve2_pkg::*;
#(
  parameter int unsigned LsuDepth    = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_we_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  output logic        id_stall_o,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_full_o,
  input  logic        vec_valid_i,
  input  logic [4:0]  vec_waddr_i,
  input  logic [31:0] vec_wdata_i,
  output logic        vec_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        hazard_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);
  localparam int unsigned CW = $clog2(LsuDepth) + 1;
  rf_wr_req_t head;
  rf_wr_req_t req;
  logic [LsuDepth-1:0][4:0] entry_waddr;
  logic [LsuDepth-1:0] entry_valid;
  logic [CW-1:0] count;
  logic [3:0] starve_cnt;
  logic fifo_ne;
  logic lsu_gnt;
  logic id_gnt;
  logic vec_gnt;
  logic starved;
  logic push;
  logic pop;
  wr_src_e src;
  cve2_rf_wr_fifo #(
    .Depth(LsuDepth)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (push),
    .wdata_i       (rf_wr_req_t'({lsu_waddr_i, lsu_wdata_i})),
    .pop_i         (pop),
    .head_o        (head),
    .entry_waddr_o (entry_waddr),
    .valid_o       (entry_valid),
    .count_o       (count)
  );
  // Fixed priority LSU > (starved vector) > ID > vector, muxed onto the write port with no added latency
  always_comb begin
    fifo_ne = count != '0;
    starved = starve_cnt == 4'(StarveLimit);
    lsu_gnt = !rst_i & (fifo_ne | lsu_we_i);
    vec_gnt = !rst_i & vec_valid_i & !lsu_gnt & (starved | !id_we_i);
    id_gnt = !rst_i & id_we_i & !lsu_gnt & !vec_gnt;
    id_stall_o = !rst_i & id_we_i & !id_gnt;
    vec_ready_o = vec_gnt;
    pop = !rst_i & fifo_ne;
    push = !rst_i & lsu_we_i & fifo_ne;
    src = lsu_gnt ? WrSrcLsu : id_gnt ? WrSrcId : vec_gnt ? WrSrcVec : WrSrcNone;
    req = (src == WrSrcLsu) ? (fifo_ne ? head : rf_wr_req_t'({lsu_waddr_i, lsu_wdata_i})) :
          (src == WrSrcId)  ? rf_wr_req_t'({id_waddr_i, id_wdata_i}) :
          (src == WrSrcVec) ? rf_wr_req_t'({vec_waddr_i, vec_wdata_i}) : '0;
    rf_we_o = (src != WrSrcNone) & (req.waddr != '0);
    rf_waddr_o = req.waddr;
    rf_wdata_o = req.wdata;
    lsu_full_o = !rst_i & ((count == CW'(LsuDepth)) | ((count == CW'(LsuDepth - 1)) & lsu_we_i & !pop));
    hazard_o = vec_valid_i & (((rs1_addr_i != '0) & (rs1_addr_i == vec_waddr_i)) |
                              ((rs2_addr_i != '0) & (rs2_addr_i == vec_waddr_i)));
    for (int i = 0; i < LsuDepth; i++)
      hazard_o = hazard_o | (entry_valid[i] & (((rs1_addr_i != '0) & (rs1_addr_i == entry_waddr[i])) |
                                               ((rs2_addr_i != '0) & (rs2_addr_i == entry_waddr[i]))));
  end
  // Counts cycles a valid vector result loses; saturates so it keeps outranking ID until accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt <= '0;
    else starve_cnt <= (!vec_valid_i | vec_ready_o) ? '0 : starved ? starve_cnt : starve_cnt + 4'd1;
  end
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0({lsu_gnt, id_gnt, vec_gnt}))
    else $error("multiple write sources granted");
  assert property (@(posedge clk_i) disable iff (rst_i)
    id_stall_o |=> (id_we_i & $stable({id_waddr_i, id_wdata_i})))
    else $error("id inputs changed while stalled");
  assert property (@(posedge clk_i) disable iff (rst_i)
    (vec_valid_i & !vec_ready_o) |=> (vec_valid_i & $stable({vec_waddr_i, vec_wdata_i})))
    else $error("vec inputs changed while waiting");
endmodule

// File: tb/tb_cve2_rf_wport_arbiter.sv
// tb_cve2_rf_wport_arbiter: directed and random checks against a priority/queue reference model
module tb_cve2_rf_wport_arbiter;
  localparam int D = 2;
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic id_we_i = 1'b0;
  logic [4:0] id_waddr_i = '0;
  logic [31:0] id_wdata_i = '0;
  logic id_stall_o;
  logic lsu_we_i = 1'b0;
  logic [4:0] lsu_waddr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic lsu_full_o;
  logic vec_valid_i = 1'b0;
  logic [4:0] vec_waddr_i = '0;
  logic [31:0] vec_wdata_i = '0;
  logic vec_ready_o;
  logic [4:0] rs1_addr_i = '0;
  logic [4:0] rs2_addr_i = '0;
  logic hazard_o;
  logic rf_we_o;
  logic [4:0] rf_waddr_o;
  logic [31:0] rf_wdata_o;
  int n_cmp = 0;
  int n_bad = 0;
  int starve = 0;
  bit prev_stall = 0;
  bit prev_wait = 0;
  logic [36:0] q[$];

  always #5 clk = ~clk;

  cve2_rf_wport_arbiter #(.LsuDepth(D), .StarveLimit(SL)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_we_i(id_we_i), .id_waddr_i(id_waddr_i), .id_wdata_i(id_wdata_i), .id_stall_o(id_stall_o),
    .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_full_o(lsu_full_o),
    .vec_valid_i(vec_valid_i), .vec_waddr_i(vec_waddr_i), .vec_wdata_i(vec_wdata_i), .vec_ready_o(vec_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .hazard_o(hazard_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hazard();
    logic [4:0] s1 = rs1_addr_i;
    logic [4:0] s2 = rs2_addr_i;
    bit h = 0;
    foreach (q[i]) if ((s1 != 0 && q[i][36:32] == s1) || (s2 != 0 && q[i][36:32] == s2)) h = 1;
    if (vec_valid_i && ((s1 != 0 && vec_waddr_i == s1) || (s2 != 0 && vec_waddr_i == s2))) h = 1;
    return h;
  endfunction

  task automatic cyc(input int r, input int iwe, input int ia, input logic [31:0] idat,
                     input int lwe, input int la, input logic [31:0] ldat,
                     input int vv, input int va, input logic [31:0] vdat, input int s1, input int s2);
    int g;
    logic [36:0] w;
    bit ewe, estall, eready, efull, ne;
    rst_i = r != 0;
    id_we_i = iwe != 0; id_waddr_i = 5'(ia); id_wdata_i = idat;
    lsu_we_i = lwe != 0; lsu_waddr_i = 5'(la); lsu_wdata_i = ldat;
    vec_valid_i = vv != 0; vec_waddr_i = 5'(va); vec_wdata_i = vdat;
    rs1_addr_i = 5'(s1); rs2_addr_i = 5'(s2);
    @(negedge clk);
    ne = q.size() != 0;
    g = 0;
    w = '0;
    if (r == 0) begin
      if (ne) begin g = 1; w = q[0]; end
      else if (lwe != 0) begin g = 1; w = {5'(la), ldat}; end
      else if (vv != 0 && (starve >= SL || iwe == 0)) begin g = 3; w = {5'(va), vdat}; end
      else if (iwe != 0) begin g = 2; w = {5'(ia), idat}; end
    end
    ewe = g != 0 && w[36:32] != 0;
    estall = r == 0 && iwe != 0 && g != 2;
    eready = g == 3;
    efull = r == 0 && (q.size() == D || (q.size() == D - 1 && lwe != 0 && !ne));
    chk("rf_we", 32'(rf_we_o), 32'(ewe));
    if (ewe) begin
      chk("rf_waddr", 32'(rf_waddr_o), 32'(w[36:32]));
      chk("rf_wdata", rf_wdata_o, w[31:0]);
    end
    chk("id_stall", 32'(id_stall_o), 32'(estall));
    chk("vec_ready", 32'(vec_ready_o), 32'(eready));
    chk("lsu_full", 32'(lsu_full_o), 32'(efull));
    if (r == 0) chk("hazard", 32'(hazard_o), 32'(ref_hazard()));
    if (r != 0) begin
      q.delete();
      starve = 0;
    end else begin
      if (ne) void'(q.pop_front());
      if (lwe != 0 && ne) q.push_back({5'(la), ldat});
      starve = (vv == 0 || eready) ? 0 : (starve < SL ? starve + 1 : starve);
    end
    prev_stall = r == 0 && estall;
    prev_wait = r == 0 && vv != 0 && !eready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr, riwe, ria, rlwe, rla, rvv, rva, rs1, rs2;
    logic [31:0] rid, rld, rvd;
    riwe = 0; ria = 0; rid = '0; rvv = 0; rva = 0; rvd = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 'h0, 0, 0, 'h0, 0, 0, 'h0, 0, 0);
    cyc(1, 1, 3, 'h1, 1, 4, 'h2, 1, 5, 'h3, 0, 0);
    cyc(0, 0, 0, 'h0, 0, 0, 'h0, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 5, 'hA5, 0, 0, 'h0, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 3, 'h11, 1, 4, 'h22, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 3, 'h11, 0, 0, 'h0, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 10, 'h33, 1, 1, 'h101, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 10, 'h33, 1, 2, 'h102, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 10, 'h33, 1, 3, 'h103, 0, 0, 'h0, 0, 0);
    cyc(0, 1, 10, 'h33, 0, 0, 'h0, 0, 0, 'h0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 6, 32'h40 + 32'(i), 0, 0, 'h0, 1, 9, 'h99, 0, 0);
    cyc(0, 1, 6, 'h44, 0, 0, 'h0, 1, 12, 'hCC, 0, 0);
    cyc(0, 0, 0, 'h0, 0, 0, 'h0, 1, 12, 'hCC, 0, 0);
    cyc(0, 1, 7, 'h50, 0, 0, 'h0, 1, 9, 'h90, 9, 0);
    cyc(0, 1, 7, 'h51, 0, 0, 'h0, 1, 9, 'h90, 0, 9);
    cyc(0, 1, 7, 'h52, 0, 0, 'h0, 1, 9, 'h90, 7, 0);
    cyc(0, 1, 7, 'h53, 0, 0, 'h0, 1, 9, 'h90, 0, 0);
    cyc(0, 0, 0, 'h0, 0, 0, 'h0, 1, 9, 'h90, 0, 0);
    cyc(0, 1, 0, 'hDEAD, 0, 0, 'h0, 0, 0, 'h0, 0, 0);
    cyc(0, 0, 0, 'h0, 1, 0, 'hBEEF, 0, 0, 'h0, 0, 0);
    cyc(0, 0, 0, 'h0, 0, 0, 'h0, 1, 0, 'hCAFE, 0, 0);
    cyc(0, 1, 8, 'h1, 1, 9, 'h2, 1, 11, 'h3, 11, 0);
    cyc(1, 1, 8, 'h1, 1, 9, 'h2, 1, 11, 'h3, 0, 0);
    cyc(0, 0, 0, 'h0, 0, 0, 'h0, 0, 0, 'h0, 9, 8);
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 49) == 0) ? 1 : 0;
      if (!prev_stall) begin
        riwe = ($urandom_range(0, 2) != 0) ? 1 : 0;
        ria = int'($urandom_range(0, 7));
        rid = $urandom;
      end
      rlwe = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rla = int'($urandom_range(0, 7));
      rld = $urandom;
      if (!prev_wait) begin
        rvv = ($urandom_range(0, 2) == 0) ? 1 : 0;
        rva = int'($urandom_range(0, 7));
        rvd = $urandom;
      end
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      cyc(rr, riwe, ria, rid, rlwe, rla, rld, rvv, rva, rvd, rs1, rs2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
